adder_rr_scheduler: RTL and testbench



---
 rtl/adder_sched_pkg.sv | 24 ++
 rtl/N_bit_adder.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/adder_rr_scheduler.sv | 119 +++++++++++
 tb/tb_adder_rr_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder round-robin scheduler and related
// accumulator controllers.
//   MAX_REQ  : largest supported requester count
//   req_id_t : requester tag wide enough for MAX_REQ requesters
//   rr_next  : modulo-n increment of a round-robin pointer
package adder_sched_pkg;

  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = $clog2(MAX_REQ);

  typedef logic [MAX_ID_W-1:0] req_id_t;

  // Advance a round-robin pointer, wrapping n-1 back to 0.
  function automatic req_id_t rr_next(input req_id_t ptr, input int unsigned n);
    req_id_t nxt;
    if ((32'(ptr) + 32'd1) >= n) begin
      nxt = '0;
    end else begin
      nxt = ptr + req_id_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/N_bit_adder.sv
// Combinational WIDTH-bit ripple-carry adder. The carry out of the top bit
// is not produced, so the sum is modulo 2^WIDTH.
//   a, b : operands
//   sum  : (a + b) mod 2^WIDTH
module N_bit_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit; the top stage's carry-out is intentionally absent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr and moving upward with wrap-around; the first
// active request wins.
//   req       : request vector
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted request
//   any_grant : at least one request is active
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  // Priority scan from ptr; once a winner is found, later hits are ignored.
  always_comb begin
    int unsigned idx;
    logic        hit;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    hit       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      hit = |(req & (NUM_REQ'(1) << idx));
      if (!any_grant && hit) begin
        grant     = NUM_REQ'(1) << idx;
        grant_idx = ID_W'(idx);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one ripple adder among NUM_REQ requesters. A round-robin arbiter
// picks one valid requester per cycle, its operands are added, and the sum
// is registered together with the requester index on a valid/ready output.
//   clk, reset : clock and synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (at most one bit high)
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   out_valid  : registered result valid
//   out_ready  : downstream accept
//   out_sum    : registered (a + b) mod 2^WIDTH
//   out_id     : index of the requester that produced out_sum
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [ID_W-1:0]          out_id
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("adder_rr_scheduler: NUM_REQ must be in 2..%0d", MAX_REQ);
  end

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               load_en;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   sum;
  logic               out_valid_nxt;
  logic [WIDTH-1:0]   out_sum_nxt;
  logic [ID_W-1:0]    out_id_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Output register may load when empty or draining this cycle; never in reset.
  always_comb begin
    load_en   = !out_valid || out_ready;
    accept    = any_grant && load_en && !reset;
    req_ready = accept ? grant : '0;
  end

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
        sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  N_bit_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a   (sel_a),
    .b   (sel_b),
    .sum (sum)
  );

  // Next state: load on accept, clear valid on a drain with no refill, else hold.
  // The pointer only moves on an accept, so a stalled winner keeps priority.
  always_comb begin
    out_valid_nxt = out_valid;
    out_sum_nxt   = out_sum;
    out_id_nxt    = out_id;
    rr_ptr_nxt    = rr_ptr;
    if (accept) begin
      out_valid_nxt = 1'b1;
      out_sum_nxt   = sum;
      out_id_nxt    = grant_idx;
      rr_ptr_nxt    = ID_W'(rr_next(req_id_t'(grant_idx), NUM_REQ));
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Output and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= out_valid_nxt;
      out_sum   <= out_sum_nxt;
      out_id    <= out_id_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Testbench for adder_rr_scheduler: a per-cycle table of inputs with the
// expected req_ready and out_valid, and a scoreboard of expected results
// popped as the output channel transfers.
module tb_adder_rr_scheduler;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned N_ROWS  = 24;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_sum;
  logic [ID_W-1:0]          out_id;

  always #5 clk = ~clk;

  adder_rr_scheduler #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_sum;
  } row_t;

  typedef struct {
    logic [7:0] sum;
    logic [1:0] id;
  } exp_t;

  row_t rows [N_ROWS];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic started  = 1'b0;

  // Round-robin operands: requester i sends a = 65+i, b = 66.
  localparam logic [31:0] RR_A = 32'h44434241;
  localparam logic [31:0] RR_B = 32'h42424242;
  // Backpressure operands: req1 10+1, req3 30+3.
  localparam logic [31:0] BP_A = 32'h1E000A00;
  localparam logic [31:0] BP_B = 32'h03000100;

  function automatic row_t mk(input logic rst, input logic [3:0] valid,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic ordy, input logic [3:0] exp_ready,
                              input logic exp_ov, input logic [7:0] exp_sum);
    row_t r;
    r.rst = rst; r.valid = valid; r.a = a; r.b = b; r.ordy = ordy;
    r.exp_ready = exp_ready; r.exp_ov = exp_ov; r.exp_sum = exp_sum;
    return r;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: compares the head of the scoreboard while out_valid is
  // high (repeatedly during a stall) and pops it when the transfer happens.
  always @(negedge clk) begin
    if (started && reset === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got sum %0d id %0d, expected no output", out_sum, out_id);
      end else begin
        check("out_sum", 32'(out_sum), 32'(sb[0].sum));
        check("out_id", 32'(out_id), 32'(sb[0].id));
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    exp_t e;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b0;

    //             rst valid    a              b              rdy exp_ready ov sum
    // reset with all requesters valid
    rows[0]  = mk(1, 4'b1111, RR_A,          RR_B,          1, 4'b0000, 0, 8'd0);
    rows[1]  = mk(1, 4'b1111, RR_A,          RR_B,          1, 4'b0000, 0, 8'd0);
    // round-robin with all valid, no bubbles
    rows[2]  = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b0001, 0, 8'd131);
    rows[3]  = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b0010, 1, 8'd132);
    rows[4]  = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b0100, 1, 8'd133);
    rows[5]  = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b1000, 1, 8'd134);
    rows[6]  = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b0001, 1, 8'd131);
    // single add on requester 2
    rows[7]  = mk(0, 4'b0100, 32'h00400000,  32'h00400000,  1, 4'b0100, 1, 8'd128);
    // pointer at 3: overflow on req 3, then req 0
    rows[8]  = mk(0, 4'b1001, 32'hFF000010,  32'h01000020,  1, 4'b1000, 1, 8'd0);
    rows[9]  = mk(0, 4'b0001, 32'hFF000010,  32'h01000020,  1, 4'b0001, 1, 8'd48);
    // 3-cycle stall with req 1 and 3 waiting, then drain 1 then 3
    rows[10] = mk(0, 4'b1010, BP_A,          BP_B,          0, 4'b0000, 1, 8'd0);
    rows[11] = mk(0, 4'b1010, BP_A,          BP_B,          0, 4'b0000, 1, 8'd0);
    rows[12] = mk(0, 4'b1010, BP_A,          BP_B,          0, 4'b0000, 1, 8'd0);
    rows[13] = mk(0, 4'b1010, BP_A,          BP_B,          1, 4'b0010, 1, 8'd11);
    rows[14] = mk(0, 4'b1000, BP_A,          BP_B,          1, 4'b1000, 1, 8'd33);
    rows[15] = mk(0, 4'b0000, 32'h0,         32'h0,         1, 4'b0000, 1, 8'd0);
    rows[16] = mk(0, 4'b0000, 32'h0,         32'h0,         1, 4'b0000, 0, 8'd0);
    // load into an empty register with out_ready low, stall, reset mid-stall
    rows[17] = mk(0, 4'b0100, 32'h00010000,  32'h00020000,  0, 4'b0100, 0, 8'd3);
    rows[18] = mk(0, 4'b0000, 32'h0,         32'h0,         0, 4'b0000, 1, 8'd0);
    rows[19] = mk(1, 4'b1111, RR_A,          RR_B,          0, 4'b0000, 1, 8'd0);
    // pointer back at 0 after reset
    rows[20] = mk(0, 4'b1111, RR_A,          RR_B,          1, 4'b0001, 0, 8'd131);
    rows[21] = mk(0, 4'b1110, RR_A,          RR_B,          1, 4'b0010, 1, 8'd132);
    rows[22] = mk(0, 4'b0000, 32'h0,         32'h0,         1, 4'b0000, 1, 8'd0);
    rows[23] = mk(0, 4'b0000, 32'h0,         32'h0,         1, 4'b0000, 0, 8'd0);

    @(posedge clk);
    #1;
    started = 1'b1;

    for (int r = 0; r < int'(N_ROWS); r++) begin
      reset     = rows[r].rst;
      req_valid = rows[r].valid;
      req_a     = rows[r].a;
      req_b     = rows[r].b;
      out_ready = rows[r].ordy;
      // A reset discards whatever result was pending.
      if (rows[r].rst) sb.delete();
      #1;
      check($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(rows[r].exp_ready));
      check($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(rows[r].exp_ov));
      if (rows[r].exp_ready != 4'b0000) begin
        e.sum = rows[r].exp_sum;
        e.id  = onehot_idx(rows[r].exp_ready);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
